// File: rtl/ram_load_arbiter.sv
// ram_load_arbiter: shares the system RAM port between the 6502 and the host
// download stream. Download bytes queue in a small FIFO and are written in the
// idle cycle right after each CPU clock enable. The CPU is held in reset for
// the whole load.
module ram_load_arbiter #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk25,
    input  logic              rst,
    input  logic              cpu_clken,
    input  logic [ADDR_W-1:0] cpu_ab,
    input  logic              cpu_ram_cs,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_dbo,
    input  logic              dl_active,
    input  logic              dl_wr,
    input  logic [15:0]       dl_addr,
    input  logic [7:0]        dl_data,
    output logic              dl_wait,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [7:0]        ram_din,
    output logic              cpu_hold_rst,
    output logic              load_done,
    output logic              overflow,
    output logic [ADDR_W:0]   bytes_loaded
);

    localparam int unsigned PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W    = PTR_W + 1;
    localparam int unsigned ENTRY_W  = ADDR_W + 8;
    localparam int unsigned LOADED_W = ADDR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                clken_dly_q, clken_dly_d;
    logic                dl_wait_q, dl_wait_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [LOADED_W-1:0] loaded_q, loaded_d;
    logic [ENTRY_W-1:0]  fifo_mem [FIFO_DEPTH];

    logic                fifo_empty_c;
    logic                fifo_full_c;
    logic                in_range_c;
    logic                push_c;
    logic                drop_c;
    logic                dma_slot_c;
    logic [ENTRY_W-1:0]  head_c;

    // Write qualification and the one-per-CPU-cycle DMA slot
    always_comb begin
        fifo_empty_c = (count_q == CNT_W'(0));
        fifo_full_c  = (count_q == CNT_W'(FIFO_DEPTH));
        in_range_c   = (32'(dl_addr) < (32'd1 << ADDR_W));
        push_c       = dl_wr && (state_q == S_LOAD) && in_range_c && !fifo_full_c;
        drop_c       = dl_wr && (state_q == S_LOAD) && in_range_c && fifo_full_c;
        dma_slot_c   = ((state_q == S_LOAD) || (state_q == S_DRAIN)) && !fifo_empty_c
                       && !cpu_clken && clken_dly_q;
        head_c       = fifo_mem[rd_ptr_q];
    end

    // Load sequencing FSM and status flags
    always_comb begin
        state_d     = state_q;
        overflow_d  = overflow_q;
        loaded_d    = loaded_q;
        clken_dly_d = cpu_clken;
        case (state_q)
            S_IDLE: begin
                if (dl_active) begin
                    state_d    = S_LOAD;
                    overflow_d = 1'b0;
                    loaded_d   = '0;
                end
            end
            S_LOAD: begin
                if (!dl_active) begin
                    state_d = (fifo_empty_c && !push_c) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (dl_active) begin
                    state_d = S_LOAD;
                end else if (fifo_empty_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (drop_c) begin
            overflow_d = 1'b1;
        end
        // Saturates once the MSB (2^ADDR_W) is reached
        if (dma_slot_c && !loaded_q[ADDR_W]) begin
            loaded_d = loaded_q + LOADED_W'(1);
        end
        hold_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (dma_slot_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push_c && !dma_slot_c) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push_c && dma_slot_c) begin
            count_d = count_q - CNT_W'(1);
        end
        dl_wait_d = (count_d >= CNT_W'(FIFO_DEPTH - 1));
    end

    // State and control registers
    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            clken_dly_q <= 1'b0;
            dl_wait_q   <= 1'b0;
            hold_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
            loaded_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            clken_dly_q <= clken_dly_d;
            dl_wait_q   <= dl_wait_d;
            hold_q      <= hold_d;
            done_q      <= done_d;
            overflow_q  <= overflow_d;
            loaded_q    <= loaded_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk25) begin
        if (push_c) begin
            fifo_mem[wr_ptr_q] <= {dl_addr[ADDR_W-1:0], dl_data};
        end
    end

    // RAM port mux: DMA owns the slot cycle, CPU passes through otherwise
    always_comb begin
        ram_addr = cpu_ab;
        ram_din  = cpu_dbo;
        ram_we   = cpu_we && cpu_ram_cs;
        if (dma_slot_c) begin
            ram_addr = head_c[ENTRY_W-1:8];
            ram_din  = head_c[7:0];
            ram_we   = 1'b1;
        end
    end

    assign dl_wait      = dl_wait_q;
    assign cpu_hold_rst = hold_q;
    assign load_done    = done_q;
    assign overflow     = overflow_q;
    assign bytes_loaded = loaded_q;

endmodule

// File: tb/tb_ram_load_arbiter.sv
// Directed bench for ram_load_arbiter: downloads are scored against a queue of
// expected RAM writes, which are popped when the DUT performs a DMA write.
`timescale 1ns/1ps
module tb_ram_load_arbiter;

    localparam int unsigned ADDR_W     = 13;
    localparam int unsigned FIFO_DEPTH = 4;

    logic              clk25;
    logic              rst;
    logic              cpu_clken;
    logic [ADDR_W-1:0] cpu_ab;
    logic              cpu_ram_cs;
    logic              cpu_we;
    logic [7:0]        cpu_dbo;
    logic              dl_active;
    logic              dl_wr;
    logic [15:0]       dl_addr;
    logic [7:0]        dl_data;
    logic              dl_wait;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [7:0]        ram_din;
    logic              cpu_hold_rst;
    logic              load_done;
    logic              overflow;
    logic [ADDR_W:0]   bytes_loaded;

    ram_load_arbiter #(.ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk25        (clk25),
        .rst          (rst),
        .cpu_clken    (cpu_clken),
        .cpu_ab       (cpu_ab),
        .cpu_ram_cs   (cpu_ram_cs),
        .cpu_we       (cpu_we),
        .cpu_dbo      (cpu_dbo),
        .dl_active    (dl_active),
        .dl_wr        (dl_wr),
        .dl_addr      (dl_addr),
        .dl_data      (dl_data),
        .dl_wait      (dl_wait),
        .ram_addr     (ram_addr),
        .ram_we       (ram_we),
        .ram_din      (ram_din),
        .cpu_hold_rst (cpu_hold_rst),
        .load_done    (load_done),
        .overflow     (overflow),
        .bytes_loaded (bytes_loaded)
    );

    int                n_cmp;
    int                n_err;
    logic [ADDR_W+7:0] exp_q [$];
    int                exp_loaded;
    bit                exp_ovf;
    logic [7:0]        ram_model [2**ADDR_W];

    // 25 MHz clock
    initial begin
        clk25 = 1'b0;
        forever #20 clk25 = ~clk25;
    end

    // CPU clock enable: one cycle in every 25
    initial begin
        int cnt;
        cnt       = 0;
        cpu_clken = 1'b0;
        forever begin
            @(posedge clk25);
            #1;
            cpu_clken = (cnt == 24);
            cnt       = (cnt == 24) ? 0 : cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: DMA writes must land exactly in the cycle after a CPU enable,
    // in FIFO order, whenever a byte is pending
    initial begin
        logic              prev_clken;
        logic              slot_exp;
        logic              dma_obs;
        logic [ADDR_W+7:0] e;
        prev_clken = 1'b0;
        forever begin
            @(negedge clk25);
            if (ram_we === 1'b1) begin
                ram_model[ram_addr] = ram_din;
            end
            slot_exp = prev_clken && !cpu_clken && (exp_q.size() > 0);
            dma_obs  = (ram_we === 1'b1) && !(cpu_we && cpu_ram_cs);
            if (slot_exp || dma_obs) begin
                check("dma_slot", 32'(dma_obs), 32'(slot_exp));
                if (slot_exp) begin
                    e = exp_q.pop_front();
                    check("dma_addr", 32'(ram_addr), 32'(e[ADDR_W+7:8]));
                    check("dma_data", 32'(ram_din), 32'(e[7:0]));
                end
            end
            prev_clken = cpu_clken;
        end
    end

    task automatic step();
        @(posedge clk25);
        #1;
    endtask

    // Leaves the caller at the negedge of a cycle with cpu_clken high
    task automatic wait_clken();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk25);
            if (cpu_clken) seen = 1'b1;
        end
        check("clken_seen", 32'(seen), 32'd1);
    endtask

    task automatic start_load();
        dl_active  = 1'b1;
        exp_loaded = 0;
        exp_ovf    = 1'b0;
    endtask

    // One download strobe; called and returns at posedge+1
    task automatic dl_byte(input logic [15:0] a, input logic [7:0] d);
        bit in_range;
        bit accept;
        bit drop;
        bit exp_wait;
        in_range = (32'(a) < (32'd1 << ADDR_W));
        accept   = in_range && (exp_q.size() < FIFO_DEPTH);
        drop     = in_range && (exp_q.size() >= FIFO_DEPTH);
        exp_wait = (exp_q.size() >= FIFO_DEPTH - 1);
        dl_wr    = 1'b1;
        dl_addr  = a;
        dl_data  = d;
        @(negedge clk25);
        check("dl_wait", 32'(dl_wait), 32'(exp_wait));
        @(posedge clk25);
        if (accept) begin
            exp_q.push_back({a[ADDR_W-1:0], d});
            exp_loaded++;
        end
        if (drop) exp_ovf = 1'b1;
        #1;
        dl_wr = 1'b0;
    endtask

    // Waits for the load_done pulse; cpu_hold_rst must stay high until it ends
    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk25);
            if (load_done) seen = 1'b1;
            else check({tag, "_hold_during"}, 32'(cpu_hold_rst), 32'd1);
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_hold_in_done"}, 32'(cpu_hold_rst), 32'd1);
            check({tag, "_bytes_loaded"}, 32'(bytes_loaded), 32'(exp_loaded));
            check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
            @(negedge clk25);
            check({tag, "_done_pulse_end"}, 32'(load_done), 32'd0);
            check({tag, "_hold_fall"}, 32'(cpu_hold_rst), 32'd0);
            check({tag, "_overflow_kept"}, 32'(overflow), 32'(exp_ovf));
        end
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        exp_loaded = 0;
        exp_ovf    = 1'b0;
        rst        = 1'b1;
        cpu_ab     = 13'h0123;
        cpu_ram_cs = 1'b0;
        cpu_we     = 1'b0;
        cpu_dbo    = 8'h77;
        dl_active  = 1'b0;
        dl_wr      = 1'b0;
        dl_addr    = 16'h0000;
        dl_data    = 8'h00;

        // Reset values and CPU pass-through during reset
        @(negedge clk25);
        check("rst_hold", 32'(cpu_hold_rst), 32'd0);
        check("rst_wait", 32'(dl_wait), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_loaded", 32'(bytes_loaded), 32'd0);
        check("rst_ram_addr", 32'(ram_addr), 32'h0123);
        check("rst_ram_din", 32'(ram_din), 32'h77);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // Basic 3-byte load
        wait_clken();
        step();
        start_load();
        @(negedge clk25);
        check("t1_hold_pre", 32'(cpu_hold_rst), 32'd0);
        step();
        @(negedge clk25);
        check("t1_hold_rise", 32'(cpu_hold_rst), 32'd1);
        step();
        dl_byte(16'h0000, 8'hA9);
        dl_byte(16'h0001, 8'h01);
        dl_byte(16'h0002, 8'h60);
        dl_active = 1'b0;
        wait_done("t1");
        check("t1_ram0", 32'(ram_model[0]), 32'hA9);
        check("t1_ram1", 32'(ram_model[1]), 32'h01);
        check("t1_ram2", 32'(ram_model[2]), 32'h60);
        check("t1_loaded3", 32'(bytes_loaded), 32'd3);

        // Burst of 10 ignoring dl_wait: 4 accepted, rest dropped
        wait_clken();
        step();
        start_load();
        step();
        for (int i = 0; i < 10; i++) begin
            dl_byte(16'h0100 + 16'(i), 8'h10 + 8'(i));
        end
        dl_active = 1'b0;
        @(negedge clk25);
        check("t2_ovf_set", 32'(overflow), 32'd1);
        wait_done("t2");
        check("t2_loaded4", 32'(bytes_loaded), 32'd4);
        check("t2_ram_last", 32'(ram_model[13'h0103]), 32'h13);

        // Out-of-range download addresses are silently ignored
        wait_clken();
        step();
        start_load();
        step();
        dl_byte(16'h2000, 8'hDE);
        dl_byte(16'hE000, 8'hAD);
        dl_active = 1'b0;
        wait_done("t3");
        check("t3_loaded0", 32'(bytes_loaded), 32'd0);
        check("t3_ovf_clear", 32'(overflow), 32'd0);

        // dl_active drops with 3 queued and re-asserts during DRAIN
        wait_clken();
        step();
        start_load();
        step();
        dl_byte(16'h0200, 8'hC1);
        dl_byte(16'h0201, 8'hC2);
        dl_byte(16'h0202, 8'hC3);
        dl_active = 1'b0;
        @(negedge clk25);
        check("t4_hold_a", 32'(cpu_hold_rst), 32'd1);
        step();
        @(negedge clk25);
        check("t4_hold_b", 32'(cpu_hold_rst), 32'd1);
        step();
        dl_active = 1'b1;
        @(negedge clk25);
        check("t4_hold_c", 32'(cpu_hold_rst), 32'd1);
        step();
        dl_byte(16'h0203, 8'hC4);
        dl_active = 1'b0;
        wait_done("t4");
        check("t4_ram0", 32'(ram_model[13'h0200]), 32'hC1);
        check("t4_ram3", 32'(ram_model[13'h0203]), 32'hC4);

        // Reset in DRAIN with 2 bytes still queued
        wait_clken();
        step();
        start_load();
        step();
        dl_byte(16'h0300, 8'hB1);
        dl_byte(16'h0301, 8'hB2);
        dl_byte(16'h0302, 8'hB3);
        dl_active = 1'b0;
        repeat (25) step();
        check("t5_loaded1", 32'(bytes_loaded), 32'd1);
        check("t5_queued2", 32'(exp_q.size()), 32'd2);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_rst_hold", 32'(cpu_hold_rst), 32'd0);
        check("t5_rst_wait", 32'(dl_wait), 32'd0);
        check("t5_rst_done", 32'(load_done), 32'd0);
        check("t5_rst_ovf", 32'(overflow), 32'd0);
        check("t5_rst_loaded", 32'(bytes_loaded), 32'd0);
        check("t5_rst_ram_addr", 32'(ram_addr), 32'(cpu_ab));
        step();
        step();
        rst        = 1'b0;
        cpu_ab     = 13'h0100;
        cpu_dbo    = 8'h55;
        cpu_ram_cs = 1'b1;
        cpu_we     = 1'b1;
        @(negedge clk25);
        check("t5_cpu_we", 32'(ram_we), 32'd1);
        check("t5_cpu_addr", 32'(ram_addr), 32'h0100);
        check("t5_cpu_din", 32'(ram_din), 32'h55);
        step();
        cpu_we     = 1'b0;
        cpu_ram_cs = 1'b0;
        check("t5_ram_0100", 32'(ram_model[13'h0100]), 32'h55);

        // IDLE pass-through at the top of the window
        cpu_ab = 13'h1FFF;
        for (int i = 0; i < 12; i++) begin
            cpu_we     = 1'($urandom_range(0, 1));
            cpu_ram_cs = 1'($urandom_range(0, 1));
            cpu_dbo    = 8'($urandom_range(0, 255));
            @(negedge clk25);
            check("t6_addr", 32'(ram_addr), 32'h1FFF);
            check("t6_we", 32'(ram_we), 32'(cpu_we && cpu_ram_cs));
            check("t6_din", 32'(ram_din), 32'(cpu_dbo));
            check("t6_hold", 32'(cpu_hold_rst), 32'd0);
            step();
        end
        cpu_we     = 1'b0;
        cpu_ram_cs = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
